// File: rtl/conv_mem_pkg.sv
// Shared constants, csel encodings and helpers for the layer-memory arbiter.
package conv_mem_pkg;

  localparam int unsigned CM_N_REQ    = 4;
  localparam int unsigned CM_AW       = 12;
  localparam int unsigned CM_DW       = 20;
  localparam int unsigned CM_SW       = 3;
  localparam int unsigned CM_LOCK_MAX = 16;

  typedef enum logic [CM_SW-1:0] {
    CSEL_NONE = 3'd0,
    L0_MEM0   = 3'd1,
    L0_MEM1   = 3'd2,
    L1_MEM0   = 3'd3,
    L1_MEM1   = 3'd4,
    L2_MEM    = 3'd5
  } csel_e;

  typedef enum logic {
    StUnlocked,
    StLocked
  } lock_state_e;

  // Only the five real memories may be selected; 0, 6 and 7 drop the beat.
  function automatic logic csel_legal(input logic [CM_SW-1:0] sel);
    return (sel != CSEL_NONE) && (sel <= L2_MEM);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or after i_ptr, wrapping mod N.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic              w_found;
  logic [PW-1:0]     w_idx;
  int unsigned       w_sum;

  // Scan N positions starting at the pointer; grant the first hit only.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = (32'(i_ptr) + k) % N;
      w_idx = PW'(w_sum);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing the single layer-memory port.
// Bus outputs are registered; read data is tagged back to its requester.
module conv_mem_arbiter
  import conv_mem_pkg::*;
#(
  parameter int unsigned N_REQ    = CM_N_REQ,
  parameter int unsigned AW       = CM_AW,
  parameter int unsigned DW       = CM_DW,
  parameter int unsigned SW       = CM_SW,
  parameter int unsigned LOCK_MAX = CM_LOCK_MAX
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [N_REQ-1:0]    i_req_valid,
  input  logic [N_REQ-1:0]    i_req_wr,
  input  logic [N_REQ-1:0]    i_req_lock,
  input  logic [N_REQ*SW-1:0] i_req_sel,
  input  logic [N_REQ*AW-1:0] i_req_addr,
  input  logic [N_REQ*DW-1:0] i_req_wdata,
  output logic [N_REQ-1:0]    o_req_grant,
  output logic [N_REQ-1:0]    o_rsp_valid,
  output logic [DW-1:0]       o_rsp_data,
  output logic                o_err_sel,
  output logic [SW-1:0]       o_csel,
  output logic                o_cwr,
  output logic [AW-1:0]       o_caddr_wr,
  output logic [DW-1:0]       o_cdata_wr,
  output logic                o_crd,
  output logic [AW-1:0]       o_caddr_rd,
  input  logic [DW-1:0]       i_cdata_rd
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LockLast = CW'(LOCK_MAX - 1);
  localparam logic [PW-1:0] PtrLast  = PW'(N_REQ - 1);

  lock_state_e   r_state;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] r_rr_ptr;
  logic [CW-1:0] r_lock_cnt;

  logic [SW-1:0] r_csel;
  logic          r_cwr;
  logic [AW-1:0] r_caddr_wr;
  logic [DW-1:0] r_cdata_wr;
  logic          r_crd;
  logic [AW-1:0] r_caddr_rd;
  logic          r_err_sel;
  logic          r_rd_pend1;
  logic [PW-1:0] r_rd_owner1;
  logic          r_rd_pend2;
  logic [PW-1:0] r_rd_owner2;

  logic             w_owner_active;
  logic [N_REQ-1:0] w_req_eff;
  logic [N_REQ-1:0] w_grant;
  logic             w_any;
  logic [PW-1:0]    w_gidx;
  logic [PW-1:0]    w_ptr_next;
  logic             w_g_wr;
  logic             w_g_lock;
  logic             w_g_legal;
  logic [SW-1:0]    w_g_sel;
  logic [AW-1:0]    w_g_addr;
  logic [DW-1:0]    w_g_wdata;

  // While the owner still has a beat pending, mask everyone else out.
  always_comb begin
    w_owner_active = (r_state == StLocked) && i_req_valid[r_owner];
    w_req_eff      = i_req_valid;
    if (w_owner_active) begin
      w_req_eff          = '0;
      w_req_eff[r_owner] = 1'b1;
    end
  end

  rr_picker #(
    .N  (N_REQ),
    .PW (PW)
  ) u_picker (
    .i_req   (w_req_eff),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  assign o_req_grant = w_grant;

  // Encode the one-hot grant and fetch the winning requester's beat fields.
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_gidx = PW'(i);
    end
    w_any      = |w_grant;
    w_ptr_next = (w_gidx == PtrLast) ? '0 : w_gidx + 1'b1;
    w_g_wr     = i_req_wr[w_gidx];
    w_g_lock   = i_req_lock[w_gidx];
    w_g_sel    = i_req_sel[w_gidx*SW +: SW];
    w_g_addr   = i_req_addr[w_gidx*AW +: AW];
    w_g_wdata  = i_req_wdata[w_gidx*DW +: DW];
    w_g_legal  = csel_legal(w_g_sel);
  end

  // Lock FSM, round-robin pointer and locked-beat counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StUnlocked;
      r_owner    <= '0;
      r_lock_cnt <= '0;
      r_rr_ptr   <= '0;
    end else if (w_any) begin
      r_rr_ptr <= w_ptr_next;
      if (w_owner_active) begin
        // Owner beat: release on lock drop or on the LOCK_MAX-th beat.
        if (!w_g_lock || (r_lock_cnt == LockLast)) begin
          r_state    <= StUnlocked;
          r_lock_cnt <= '0;
        end else begin
          r_lock_cnt <= r_lock_cnt + 1'b1;
        end
      end else if (w_g_lock && (LOCK_MAX > 1)) begin
        r_state    <= StLocked;
        r_owner    <= w_gidx;
        r_lock_cnt <= CW'(1);
      end else begin
        r_state    <= StUnlocked;
        r_lock_cnt <= '0;
      end
    end else if (r_state == StLocked) begin
      // No grant while locked means the owner dropped valid.
      r_state    <= StUnlocked;
      r_lock_cnt <= '0;
    end
  end

  // Registered memory bus and two-stage read tag pipe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_csel      <= '0;
      r_cwr       <= 1'b0;
      r_caddr_wr  <= '0;
      r_cdata_wr  <= '0;
      r_crd       <= 1'b0;
      r_caddr_rd  <= '0;
      r_err_sel   <= 1'b0;
      r_rd_pend1  <= 1'b0;
      r_rd_owner1 <= '0;
      r_rd_pend2  <= 1'b0;
      r_rd_owner2 <= '0;
    end else begin
      r_csel     <= '0;
      r_cwr      <= 1'b0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
      r_crd      <= 1'b0;
      r_caddr_rd <= '0;
      r_err_sel  <= 1'b0;
      if (w_any) begin
        if (w_g_legal) begin
          r_csel <= w_g_sel;
          if (w_g_wr) begin
            r_cwr      <= 1'b1;
            r_caddr_wr <= w_g_addr;
            r_cdata_wr <= w_g_wdata;
          end else begin
            r_crd      <= 1'b1;
            r_caddr_rd <= w_g_addr;
          end
        end else begin
          r_err_sel <= 1'b1;
        end
      end
      r_rd_pend1  <= w_any && w_g_legal && !w_g_wr;
      r_rd_owner1 <= w_gidx;
      r_rd_pend2  <= r_rd_pend1;
      r_rd_owner2 <= r_rd_owner1;
    end
  end

  // Response strobe follows the tag pipe; data passes straight from memory.
  always_comb begin
    o_rsp_valid = '0;
    if (r_rd_pend2) o_rsp_valid[r_rd_owner2] = 1'b1;
  end

  assign o_rsp_data = i_cdata_rd;
  assign o_err_sel  = r_err_sel;
  assign o_csel     = r_csel;
  assign o_cwr      = r_cwr;
  assign o_caddr_wr = r_caddr_wr;
  assign o_cdata_wr = r_cdata_wr;
  assign o_crd      = r_crd;
  assign o_caddr_rd = r_caddr_rd;

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Self-checking bench: per-requester beat queues feed the DUT, a cycle-level
// reference model predicts grants, bus beats and read responses.
module tb_conv_mem_arbiter;

  localparam int N = 4;
  localparam int AW = 12;
  localparam int DW = 20;
  localparam int SW = 3;
  localparam int LOCK_MAX = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_wr, req_lock;
  logic [N*SW-1:0] req_sel;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_grant, rsp_valid;
  logic [DW-1:0]   rsp_data, cdata_rd, cdata_wr;
  logic            err_sel, cwr, crd;
  logic [SW-1:0]   csel;
  logic [AW-1:0]   caddr_wr, caddr_rd;

  always #5 clk = ~clk;

  conv_mem_arbiter dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .i_req_wr    (req_wr),
    .i_req_lock  (req_lock),
    .i_req_sel   (req_sel),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_req_grant (req_grant),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_err_sel   (err_sel),
    .o_csel      (csel),
    .o_cwr       (cwr),
    .o_caddr_wr  (caddr_wr),
    .o_cdata_wr  (cdata_wr),
    .o_crd       (crd),
    .o_caddr_rd  (caddr_rd),
    .i_cdata_rd  (cdata_rd)
  );

  typedef struct packed {
    logic        wr;
    logic        lock;
    logic [2:0]  sel;
    logic [11:0] addr;
    logic [19:0] wdata;
  } beat_t;

  beat_t fifo [N][64];
  int    head [N];
  int    tail [N];

  // Reference model state.
  int m_ptr, m_locked, m_owner, m_cnt;
  int rd1, rd2;
  logic [31:0] e_csel, e_cwr, e_caddr_wr, e_cdata_wr, e_crd, e_caddr_rd, e_err;

  int n_tests = 0;
  int n_fail  = 0;
  int glog[$];
  bit force_en = 1'b0;
  logic [19:0] force_val = '0;
  bit streak [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qlen(input int r);
    return tail[r] - head[r];
  endfunction

  task automatic push(input int r, input logic wr, input logic lock, input logic [2:0] sel,
                      input logic [11:0] addr, input logic [19:0] wdata);
    beat_t b;
    b.wr = wr; b.lock = lock; b.sel = sel; b.addr = addr; b.wdata = wdata;
    fifo[r][tail[r] % 64] = b;
    tail[r]++;
  endtask

  function automatic bit legal(input logic [2:0] s);
    return (s >= 3'd1) && (s <= 3'd5);
  endfunction

  // Round-robin with lock priority, from the arbitration rules.
  function automatic int model_pick();
    if (m_locked != 0 && qlen(m_owner) > 0) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (qlen((m_ptr + k) % N) > 0) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic clear_exp();
    e_csel = 0; e_cwr = 0; e_caddr_wr = 0; e_cdata_wr = 0;
    e_crd = 0; e_caddr_rd = 0; e_err = 0;
  endtask

  task automatic step(input bit r);
    int g, obs;
    logic [19:0] cd;
    beat_t b;
    @(negedge clk);
    check("csel", 32'(csel), e_csel);
    check("cwr", 32'(cwr), e_cwr);
    check("caddr_wr", 32'(caddr_wr), e_caddr_wr);
    check("cdata_wr", 32'(cdata_wr), e_cdata_wr);
    check("crd", 32'(crd), e_crd);
    check("caddr_rd", 32'(caddr_rd), e_caddr_rd);
    check("err_sel", 32'(err_sel), e_err);
    check("rsp_valid", 32'(rsp_valid), (rd2 >= 0) ? (32'd1 << rd2) : 32'd0);
    cd = force_en ? force_val : 20'($urandom);
    cdata_rd = cd;
    #1;
    if (rd2 >= 0) check("rsp_data", 32'(rsp_data), 32'(cd));
    rst = r;
    for (int i = 0; i < N; i++) begin
      b = fifo[i][head[i] % 64];
      req_valid[i] = (qlen(i) > 0);
      req_wr[i]    = (qlen(i) > 0) ? b.wr : 1'b0;
      req_lock[i]  = (qlen(i) > 0) ? b.lock : 1'b0;
      req_sel[i*SW +: SW]   = (qlen(i) > 0) ? b.sel : 3'd0;
      req_addr[i*AW +: AW]  = (qlen(i) > 0) ? b.addr : 12'd0;
      req_wdata[i*DW +: DW] = (qlen(i) > 0) ? b.wdata : 20'd0;
    end
    #1;
    obs = -1;
    for (int i = 0; i < N; i++) if (req_grant[i]) obs = i;
    if (r) begin
      m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0;
      rd1 = -1; rd2 = -1;
      clear_exp();
      return;
    end
    g = model_pick();
    check("grant", 32'(req_grant), (g >= 0) ? (32'd1 << g) : 32'd0);
    glog.push_back(obs);
    rd2 = rd1;
    rd1 = -1;
    clear_exp();
    if (g >= 0) begin
      b = fifo[g][head[g] % 64];
      head[g]++;
      if (legal(b.sel)) begin
        e_csel = 32'(b.sel);
        if (b.wr) begin
          e_cwr = 1; e_caddr_wr = 32'(b.addr); e_cdata_wr = 32'(b.wdata);
        end else begin
          e_crd = 1; e_caddr_rd = 32'(b.addr); rd1 = g;
        end
      end else begin
        e_err = 1;
      end
      m_ptr = (g + 1) % N;
      if (m_locked != 0 && g == m_owner) begin
        m_cnt++;
        if (!b.lock || m_cnt == LOCK_MAX) begin
          m_locked = 0; m_cnt = 0;
        end
      end else if (b.lock) begin
        m_locked = 1; m_owner = g; m_cnt = 1;
      end else begin
        m_locked = 0; m_cnt = 0;
      end
    end else begin
      m_locked = 0; m_cnt = 0;
    end
  endtask

  task automatic gen_random();
    logic [2:0] s;
    bit lk;
    for (int r = 0; r < N; r++) begin
      if (qlen(r) < 3 && (streak[r] || $urandom_range(99) < 35)) begin
        if ($urandom_range(9) < 8) s = 3'(1 + $urandom_range(4));
        else s = ($urandom_range(2) == 0) ? 3'd0 : 3'(6 + $urandom_range(1));
        lk = ($urandom_range(99) < (streak[r] ? 93 : 20));
        streak[r] = lk;
        push(r, 1'($urandom_range(1)), lk, s, 12'($urandom), 20'($urandom));
      end
    end
  endtask

  initial begin
    int run, cnt[N];
    int t4_exp[4];
    rst = 1'b1;
    req_valid = '0; req_wr = '0; req_lock = '0;
    req_sel = '0; req_addr = '0; req_wdata = '0; cdata_rd = '0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; streak[i] = 1'b0; end
    m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0; rd1 = -1; rd2 = -1;
    clear_exp();
    repeat (2) @(posedge clk);

    // Reset state, then a read cut off by reset.
    step(0);
    push(1, 1'b0, 1'b0, 3'd1, 12'h100, 20'h0);
    step(0);
    step(1);
    step(0);
    step(0);
    step(0);

    // Fairness: all four busy, no lock.
    glog.delete();
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < N; r++) push(r, 1'b1, 1'b0, 3'd2, 12'(r * 16 + k), 20'(k));
    repeat (17) step(0);
    for (int r = 0; r < N; r++) cnt[r] = 0;
    for (int i = 0; i < 16; i++) if (glog[i] >= 0) cnt[glog[i]]++;
    for (int r = 0; r < N; r++) check("fair_cnt", 32'(cnt[r]), 32'd4);

    // Read path with known return data.
    push(1, 1'b0, 1'b0, 3'd1, 12'h041, 20'h0);
    step(0);
    step(0);
    force_en = 1'b1; force_val = 20'h0A89E;
    step(0);
    force_en = 1'b0;
    step(0);

    // Short lock by req2 while req0 waits.
    glog.delete();
    push(2, 1'b1, 1'b1, 3'd3, 12'h010, 20'h1);
    push(2, 1'b1, 1'b1, 3'd3, 12'h011, 20'h2);
    push(2, 1'b1, 1'b0, 3'd3, 12'h012, 20'h3);
    push(0, 1'b0, 1'b0, 3'd4, 12'h020, 20'h0);
    repeat (5) step(0);
    t4_exp = '{2, 2, 2, 0};
    for (int i = 0; i < 4; i++) check("lock_seq", 32'(glog[i]), 32'(t4_exp[i]));

    // Endless lock hits LOCK_MAX and yields.
    glog.delete();
    for (int k = 0; k < 20; k++) push(1, 1'b1, 1'b1, 3'd2, 12'(k), 20'(k));
    push(3, 1'b0, 1'b0, 3'd5, 12'h7FF, 20'h0);
    repeat (24) step(0);
    run = 0;
    while (run < glog.size() && glog[run] == 1) run++;
    check("lockmax_run", 32'(run), 32'(LOCK_MAX));
    check("lockmax_next", 32'(glog[run]), 32'd3);
    repeat (3) step(0);

    // Write beat, then an illegal select.
    push(3, 1'b1, 1'b0, 3'd5, 12'd2047, 20'h01310);
    step(0);
    step(0);
    push(0, 1'b0, 1'b0, 3'd7, 12'h123, 20'h0);
    repeat (4) step(0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      gen_random();
      step(0);
    end
    for (int i = 0; i < N; i++) streak[i] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (qlen(0) + qlen(1) + qlen(2) + qlen(3) == 0) break;
      step(0);
    end
    check("drained", 32'(qlen(0) + qlen(1) + qlen(2) + qlen(3)), 32'd0);
    repeat (3) step(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
